// File: rtl/reg_writeback_buffer.sv
// reg_writeback_buffer: in-order write-back queue feeding the register file write port,
// with youngest-first forwarding over pending and in-flight writes.
module reg_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_reg,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         rf_stall,
    output logic                         reg_write,
    output logic [ADDR_W-1:0]            write_reg,
    output logic [DATA_W-1:0]            write_data,
    input  logic [ADDR_W-1:0]            fwd_reg1,
    input  logic [ADDR_W-1:0]            fwd_reg2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [DATA_W-1:0]            fwd_data1,
    output logic [DATA_W-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] q_reg  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PW-1:0]     head, tail;
    logic              push, pop;

    assign in_ready = count != CW'(DEPTH);
    assign empty    = count == '0;
    // Writes to r0 finish the handshake but are never queued.
    assign push     = in_valid && in_ready && in_reg != '0;
    assign pop      = !empty && !rf_stall;

    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[tail]  <= in_reg;
            q_data[tail] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) begin
                head       <= head + PW'(1);
                write_reg  <= q_reg[head];
                write_data <= q_data[head];
            end
            reg_write <= pop;
            count     <= count + CW'(push) - CW'(pop);
        end
    end

    // Scan oldest to youngest so the youngest match overwrites; output stage ranks lowest.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
        logic [DATA_W:0] res;
        res = '0;
        if (reg_write && write_reg == r) res = {1'b1, write_data};
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count && q_reg[head + PW'(i)] == r) res = {1'b1, q_data[head + PW'(i)]};
        return (r == '0) ? '0 : res;
    endfunction

    assign {fwd_hit1, fwd_data1} = lookup(fwd_reg1);
    assign {fwd_hit2, fwd_data2} = lookup(fwd_reg2);
endmodule

// File: tb/tb_reg_writeback_buffer.sv
// tb_reg_writeback_buffer: directed self-checking bench for reg_writeback_buffer.
module tb_reg_writeback_buffer;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, rf_stall = 0;
    logic [4:0]  in_reg = 0, fwd_reg1 = 0, fwd_reg2 = 0, write_reg;
    logic [31:0] in_data = 0, write_data, fwd_data1, fwd_data2;
    logic        reg_write, fwd_hit1, fwd_hit2, empty;
    logic [2:0]  count;
    int          total = 0, bad = 0;

    reg_writeback_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .rf_stall(rf_stall),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        in_valid = 1;
        in_reg   = r;
        in_data  = d;
    endtask

    initial begin
        // reset values
        #2;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_ready", in_ready, 1);
        check("rst_wr", {reg_write, write_reg, write_data}, 0);
        check("rst_fwd", {fwd_hit1, fwd_hit2, fwd_data1, fwd_data2}, 0);
        @(negedge clk);
        rst_n = 1;

        // single write
        fwd_reg1 = 3;
        push(3, 32'h0000FFFF);
        tick();
        in_valid = 0;
        check("s_count", count, 1);
        check("s_hit", {fwd_hit1, fwd_data1}, {1'b1, 32'h0000FFFF});
        check("s_nowr", reg_write, 0);
        tick();
        check("s_wr", {reg_write, write_reg, write_data}, {1'b1, 5'd3, 32'h0000FFFF});
        check("s_empty", empty, 1);
        check("s_hit_out", fwd_hit1, 1);
        tick();
        check("s_wr_off", {reg_write, write_reg}, {1'b0, 5'd3});
        check("s_hit_clr", {fwd_hit1, fwd_data1}, 0);

        // fill under stall
        rf_stall = 1;
        for (int i = 1; i <= 4; i++) begin
            push(5'(i), 32'h100 + i);
            tick();
        end
        check("f_ready", in_ready, 0);
        check("f_count", count, 4);
        push(5, 32'h555);
        tick();
        in_valid = 0;
        check("f_count5", count, 4);
        check("f_nowr", reg_write, 0);
        rf_stall = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("f_drain", {reg_write, write_reg, write_data}, {1'b1, 5'(i), 32'h100 + i});
        end
        tick();
        check("f_end", {reg_write, count, in_ready}, {1'b0, 3'd0, 1'b1});

        // youngest-wins forwarding
        rf_stall = 1;
        fwd_reg2 = 30;
        push(30, 32'hFFFF0000);
        tick();
        push(30, 32'h12345678);
        tick();
        in_valid = 0;
        check("y_fwd", {fwd_hit2, fwd_data2}, {1'b1, 32'h12345678});
        rf_stall = 0;
        tick();
        check("y_wr1", {reg_write, write_data}, {1'b1, 32'hFFFF0000});
        check("y_fwd1", fwd_data2, 32'h12345678);
        tick();
        check("y_wr2", {reg_write, write_data}, {1'b1, 32'h12345678});
        check("y_fwd2", {fwd_hit2, fwd_data2}, {1'b1, 32'h12345678});
        tick();
        check("y_clr", {reg_write, fwd_hit2}, 0);

        // register zero
        fwd_reg1 = 0;
        push(0, 32'hDEADBEEF);
        #1;
        check("z_ready", in_ready, 1);
        tick();
        in_valid = 0;
        check("z_count", {count, empty}, {3'd0, 1'b1});
        check("z_hit", {fwd_hit1, fwd_data1}, 0);
        tick();
        check("z_nowr", reg_write, 0);

        // simultaneous push/pop with wrap
        rf_stall = 1;
        push(10, 32'hA00A);
        tick();
        push(11, 32'hA00B);
        tick();
        check("p_count", count, 2);
        rf_stall = 0;
        for (int j = 0; j < 10; j++) begin
            push(5'(12 + j), 32'hA000 + 12 + j);
            tick();
            check("p_cnt", count, 2);
            check("p_wr", {reg_write, write_reg, write_data}, {1'b1, 5'(10 + j), 32'hA000 + 10 + j});
        end
        in_valid = 0;
        tick();
        check("p_tail1", {reg_write, write_reg, write_data}, {1'b1, 5'd20, 32'hA014});
        tick();
        check("p_tail2", {reg_write, write_reg, write_data}, {1'b1, 5'd21, 32'hA015});
        tick();
        check("p_done", {reg_write, count}, 0);

        // reset mid-operation
        rf_stall = 1;
        for (int i = 6; i <= 9; i++) begin
            push(5'(i), 32'hB000 + i);
            tick();
        end
        in_valid = 0;
        rf_stall = 0;
        fwd_reg1 = 6;
        fwd_reg2 = 9;
        tick();
        check("r_pre", {reg_write, write_reg, count}, {1'b1, 5'd6, 3'd3});
        check("r_prehit", {fwd_hit1, fwd_hit2}, 2'b11);
        #2;
        rst_n = 0;
        #1;
        check("r_wr", {reg_write, write_reg, write_data}, 0);
        check("r_count", {count, empty}, {3'd0, 1'b1});
        check("r_fwd", {fwd_hit1, fwd_hit2, fwd_data1, fwd_data2}, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r_nowr", {reg_write, count}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_writeback_buffer.md
# reg_writeback_buffer

Write-side initiator for the register file. Accepts register write-back requests from the pipeline through a valid/ready handshake and holds them in a small in-order queue. Drains one entry per cycle into the register file write port (`reg_write`/`write_reg`/`write_data`), and answers forwarding lookups for writes that are still pending, so readers never observe stale values.

## Interface
- `DEPTH`, 4, queue entries; power of two, minimum 2.
- `ADDR_W`, 5, register index width.
- `DATA_W`, 32, register data width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: pipeline presents a write request.
- `in_ready` out 1: buffer can accept; equals !full.
- `in_reg` in ADDR_W: destination register.
- `in_data` in DATA_W: value to write.
- `rf_stall` in 1: register file write port unavailable this cycle; blocks draining.
- `reg_write` out 1: write enable to register file (registered).
- `write_reg` out ADDR_W: write index to register file (registered).
- `write_data` out DATA_W: write value to register file (registered).
- `fwd_reg1`, `fwd_reg2` in ADDR_W: lookup indices (same as register file read indices).
- `fwd_hit1`, `fwd_hit2` out 1: pending write exists for the index.
- `fwd_data1`, `fwd_data2` out DATA_W: youngest pending value; 0 when no hit.
- `count` out clog2(DEPTH)+1: occupied queue entries.
- `empty` out 1: count == 0.

## Operation
- The queue is a circular FIFO with head/tail pointers and a count. Pointers wrap modulo DEPTH.
- Push happens when `in_valid && in_ready` at a rising edge. A request with `in_reg == 0` completes the handshake but is discarded: it is not stored and count does not change.
- Drain happens at a rising edge when `!empty && !rf_stall`. The head entry is popped and loaded into the output stage: `reg_write<=1`, `write_reg<=head.reg`, `write_data<=head.data`.
- When no drain occurs, `reg_write<=0`. `write_reg` and `write_data` hold their last values.
- Push and pop in the same cycle:
  - count is unchanged.
  - A push into an empty queue is not drained in the same cycle. The pushed entry is visible at the head only after the edge.
- Full: `in_ready=0` whenever count == DEPTH, even if a pop occurs in that cycle. No bypass of full.
- Forwarding (combinational):
  - Search all valid queue entries plus the output stage when `reg_write=1`.
  - Priority, youngest first: tail-1 down to head, then the output stage.
  - Index 0 never hits.
  - Both ports are independent and may match the same register.
- Ordering: writes reach the register file strictly in acceptance order. Duplicate indices are all written; the last one wins.

## Timing
- Reset values:
  - count 0, pointers 0, `empty` 1, `in_ready` 1.
  - `reg_write` 0, `write_reg` 0, `write_data` 0.
  - `fwd_hit1/2` 0, `fwd_data1/2` 0.
- Reset asserted mid-operation discards all queued and output-stage entries immediately (asynchronous). Nothing is written to the register file afterwards.
- Latency:
  - A request accepted at edge N drives `reg_write=1` from edge N+1 at the earliest, for exactly one cycle per entry.
  - The register file commits it during the low phase of that cycle.
- Forward visibility:
  - An entry hits from edge N (acceptance) through the end of the cycle in which it sits in the output stage.
  - It stops hitting at the next edge, by which time the register file holds the value.
- `rf_stall` is sampled only at the rising edge. Stall for k cycles adds k cycles of latency, and the queue keeps accepting until full.
- Throughput is one push and one drain per cycle in steady state.

## Test plan
- Single write: after reset, push reg 3 = 0x0000FFFF at edge 1.
  - `fwd_hit1=1` for `fwd_reg1=3` after edge 1.
  - `reg_write=1`, `write_reg=3`, `write_data=0x0000FFFF` for one cycle after edge 2.
  - empty=1 after edge 2; hit clears after edge 3.
- Fill and stall: hold `rf_stall=1` and push regs 1,2,3,4.
  - `in_ready=0` and count=4 after the fourth push; a fifth `in_valid` is not accepted.
  - Release the stall: four consecutive `reg_write` pulses in order 1,2,3,4, then `in_ready=1`.
- Youngest-wins forwarding: push reg 30 = 0xFFFF0000, then reg 30 = 0x12345678, with stall held.
  - `fwd_data2=0x12345678`.
  - After the first drain, `fwd_data2` stays 0x12345678 (queue entry outranks the output stage).
- Register zero: push reg 0 = 0xDEADBEEF.
  - Handshake completes and count stays 0.
  - No `reg_write` pulse follows, and `fwd_hit1=0` for `fwd_reg1=0`.
- Simultaneous push/pop with count=2:
  - count stays 2.
  - Pointers wrap correctly across 10 continuous push/pop cycles, and the drained sequence equals the pushed sequence.
- Reset mid-operation: with 3 entries queued and `reg_write=1`, pulse `rst_n` low between edges.
  - `reg_write=0`, count=0, `fwd_hit1/2=0` immediately.
  - No further writes occur.
